// File: rtl/axil_csr_irq_if.sv
// AXI-Lite slave bus bundle for the axil_csr_irq register bank.
// The master modport is the interconnect side; the slave modport is the CSR block.
interface axil_csr_irq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic                  awValid;
  logic                  awReady;
  logic [ADDR_W-1:0]     awAddr;
  logic                  wValid;
  logic                  wReady;
  logic [DATA_W-1:0]     wData;
  logic [DATA_W/8-1:0]   wStrb;
  logic                  bValid;
  logic                  bReady;
  logic [1:0]            bResp;
  logic                  arValid;
  logic                  arReady;
  logic [ADDR_W-1:0]     arAddr;
  logic                  rValid;
  logic                  rReady;
  logic [DATA_W-1:0]     rData;
  logic [1:0]            rResp;

  modport master (
    output awValid, awAddr, wValid, wData, wStrb, bReady, arValid, arAddr, rReady,
    input  awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
  );

  modport slave (
    input  awValid, awAddr, wValid, wData, wStrb, bReady, arValid, arAddr, rReady,
    output awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
  );
endinterface

// File: rtl/axil_csr_irq.sv
// axil_csr_irq: AXI-Lite control/status register bank with a per-bit
// edge/level interrupt controller (write-1-to-clear status).
// Register map (index = byte address / (DATA_W/8)):
//   0..CTRL-1           ctrl (RW, byte strobed, ctrlWr pulse on commit)
//   CTRL..CTRL+STAT-1   stat (RO)
//   then, if INTERRUPTS>0: IRQ_EN (RW), IRQ_STAT (W1C), IRQ_MODE (RW, 1=edge), IRQ_RAW (RO)
// Optional build macro AXIL_CSR_STAT_SNAPSHOT_EN: reading stat index CTRL
// snapshots every stat input so the remaining stat words read coherently.
module axil_csr_irq #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 12,
  parameter int              CTRL       = 4,
  parameter int              STAT       = 4,
  parameter int              INTERRUPTS = 8,
  parameter logic [DATA_W-1:0] CTRL_RST = {DATA_W{1'b0}}
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  axil_csr_irq_if.slave                               bus,
  output logic [CTRL*DATA_W-1:0]                      ctrl,
  output logic [CTRL-1:0]                             ctrlWr,
  input  logic [((STAT > 0) ? STAT : 1)*DATA_W-1:0]   stat,
  input  logic [((INTERRUPTS > 0) ? INTERRUPTS : 1)-1:0] interrupts,
  output logic                                        irq
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IW    = (INTERRUPTS > 0) ? INTERRUPTS : 1;
  localparam int SW    = (STAT > 0) ? STAT : 1;
  localparam int NREG  = CTRL + STAT + ((INTERRUPTS > 0) ? 4 : 0);
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int I_EN   = CTRL + STAT;
  localparam int I_ST   = CTRL + STAT + 1;
  localparam int I_MODE = CTRL + STAT + 2;
  localparam int I_RAW  = CTRL + STAT + 3;

  // Elaboration-time parameter legality
  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("axil_csr_irq: DATA_W must be 32 or 64");
  end
  if (ADDR_W < IDX_W + OFS) begin : g_bad_addr_w
    $error("axil_csr_irq: ADDR_W too small for register map");
  end
  if (CTRL < 1) begin : g_bad_ctrl
    $error("axil_csr_irq: CTRL must be >= 1");
  end
  if (STAT < 0) begin : g_bad_stat
    $error("axil_csr_irq: STAT must be >= 0");
  end
  if (INTERRUPTS < 0 || INTERRUPTS > DATA_W) begin : g_bad_irq
    $error("axil_csr_irq: INTERRUPTS must be within 0..DATA_W");
  end

  // Byte-strobed merge of new write data into an existing register value
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [BYTES-1:0]  strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < BYTES; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Bus-side state
  logic                awready_r, wready_r, arready_r, bvalid_r, rvalid_r;
  logic [1:0]          bresp_r, rresp_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                aw_held_r, w_held_r;
  logic [ADDR_W-1:0]   aw_addr_r;
  logic [DATA_W-1:0]   w_data_r;
  logic [BYTES-1:0]    w_strb_r;
  logic [DATA_W-1:0]   ctrl_r [CTRL];
  logic [CTRL-1:0]     ctrlwr_r;

  logic                aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s;
  logic [31:0]         widx_s, ridx_s;
  logic                wr_ok_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                rd_err_s;
  logic [DATA_W-1:0]   stat_view_s [SW];
  logic [IW-1:0]       irq_en_s, irq_stat_s, irq_mode_s;

  assign aw_hs_s  = bus.awValid & awready_r;
  assign w_hs_s   = bus.wValid & wready_r;
  assign b_hs_s   = bvalid_r & bus.bReady;
  assign ar_hs_s  = bus.arValid & arready_r;
  assign r_hs_s   = rvalid_r & bus.rReady;
  assign commit_s = aw_held_r & w_held_r & ~bvalid_r;
  assign widx_s   = 32'(aw_addr_r[ADDR_W-1:OFS]);
  assign ridx_s   = 32'(bus.arAddr[ADDR_W-1:OFS]);

  logic unused_s;
  assign unused_s = ^{aw_addr_r[OFS-1:0], bus.arAddr[OFS-1:0], stat};

  // Decode whether the held write targets a writable register
  always_comb begin
    wr_ok_s = 1'b0;
    if (widx_s < 32'(CTRL)) begin
      wr_ok_s = 1'b1;
    end else if ((INTERRUPTS > 0) &&
                 (widx_s == 32'(I_EN) || widx_s == 32'(I_ST) || widx_s == 32'(I_MODE))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

`ifdef AXIL_CSR_STAT_SNAPSHOT_EN
  logic [SW*DATA_W-1:0] shadow_r;

  // Capture all stat inputs when stat word 0 is read
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shadow_r <= {(SW*DATA_W){1'b0}};
    end else if ((STAT > 0) && ar_hs_s && (ridx_s == 32'(CTRL))) begin
      shadow_r <= stat;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Word 0 is live (it triggers the snapshot); later words come from the shadow
  always_comb begin
    for (int j = 0; j < SW; j++) begin
      if (j == 0) begin
        stat_view_s[j] = stat[j*DATA_W +: DATA_W];
      end else begin
        stat_view_s[j] = shadow_r[j*DATA_W +: DATA_W];
      end
    end
  end
`else
  // Every stat word reads the live input
  always_comb begin
    for (int j = 0; j < SW; j++) begin
      stat_view_s[j] = stat[j*DATA_W +: DATA_W];
    end
  end
`endif

  // Read data multiplexer, sampled into rData at the ar handshake
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    rd_err_s  = 1'b1;
    for (int i = 0; i < CTRL; i++) begin
      if (ridx_s == 32'(i)) begin
        rd_data_s = ctrl_r[i];
        rd_err_s  = 1'b0;
      end else begin
        rd_data_s = rd_data_s;
      end
    end
    for (int j = 0; j < STAT; j++) begin
      if (ridx_s == 32'(CTRL + j)) begin
        rd_data_s = stat_view_s[j];
        rd_err_s  = 1'b0;
      end else begin
        rd_data_s = rd_data_s;
      end
    end
    if (INTERRUPTS > 0) begin
      case (ridx_s)
        32'(I_EN):   begin rd_data_s = DATA_W'(irq_en_s);   rd_err_s = 1'b0; end
        32'(I_ST):   begin rd_data_s = DATA_W'(irq_stat_s); rd_err_s = 1'b0; end
        32'(I_MODE): begin rd_data_s = DATA_W'(irq_mode_s); rd_err_s = 1'b0; end
        32'(I_RAW):  begin rd_data_s = DATA_W'(interrupts); rd_err_s = 1'b0; end
        default:     begin rd_data_s = rd_data_s;           rd_err_s = rd_err_s; end
      endcase
    end else begin
      rd_data_s = rd_data_s;
    end
  end

  // Write channel: independent AW/W buffers, commit, ctrl update and B response
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_addr_r <= {ADDR_W{1'b0}};
      w_data_r  <= {DATA_W{1'b0}};
      w_strb_r  <= {BYTES{1'b0}};
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      ctrlwr_r  <= {CTRL{1'b0}};
      for (int i = 0; i < CTRL; i++) begin
        ctrl_r[i] <= CTRL_RST;
      end
    end else begin
      ctrlwr_r <= {CTRL{1'b0}};
      if (b_hs_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b0;
        awready_r <= 1'b1;
        wready_r  <= 1'b1;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
          aw_addr_r <= bus.awAddr;
          awready_r <= 1'b0;
        end else begin
          awready_r <= ~aw_held_r;
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          w_data_r <= bus.wData;
          w_strb_r <= bus.wStrb;
          wready_r <= 1'b0;
        end else begin
          wready_r <= ~w_held_r;
        end
        if (commit_s) begin
          bvalid_r <= 1'b1;
          bresp_r  <= wr_ok_s ? 2'b00 : 2'b10;
          for (int i = 0; i < CTRL; i++) begin
            if (widx_s == 32'(i)) begin
              ctrl_r[i]   <= merge_bytes(ctrl_r[i], w_data_r, w_strb_r);
              ctrlwr_r[i] <= |w_strb_r;
            end else begin
              ctrl_r[i] <= ctrl_r[i];
            end
          end
        end else begin
          bvalid_r <= bvalid_r;
        end
      end
    end
  end

  // Read channel: one outstanding read, data held until rReady
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= 2'b00;
    end else if (r_hs_s) begin
      rvalid_r  <= 1'b0;
      arready_r <= 1'b1;
    end else if (ar_hs_s) begin
      rvalid_r  <= 1'b1;
      arready_r <= 1'b0;
      rdata_r   <= rd_data_s;
      rresp_r   <= rd_err_s ? 2'b10 : 2'b00;
    end else begin
      arready_r <= ~rvalid_r;
    end
  end

  if (INTERRUPTS > 0) begin : g_irq
    logic [IW-1:0]     en_r, st_r, mode_r, prev_r;
    logic              irq_r;
    logic [IW-1:0]     event_s, set_s, clr_s, cover_s;
    logic [DATA_W-1:0] en_wr_s, mode_wr_s;

    // Per-bit event detection, W1C mask and byte-strobed register write values
    always_comb begin
      for (int g = 0; g < IW; g++) begin
        cover_s[g] = w_strb_r[g/8];
      end
      event_s = (mode_r & interrupts & ~prev_r) | (~mode_r & interrupts);
      set_s   = event_s & en_r;
      if (commit_s && (widx_s == 32'(I_ST))) begin
        clr_s = w_data_r[IW-1:0] & cover_s;
      end else begin
        clr_s = {IW{1'b0}};
      end
      en_wr_s   = merge_bytes(DATA_W'(en_r), w_data_r, w_strb_r);
      mode_wr_s = merge_bytes(DATA_W'(mode_r), w_data_r, w_strb_r);
    end

    // Interrupt enable/mode/status registers, edge history and irq output
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        en_r   <= {IW{1'b0}};
        st_r   <= {IW{1'b0}};
        mode_r <= {IW{1'b0}};
        prev_r <= {IW{1'b0}};
        irq_r  <= 1'b0;
      end else begin
        prev_r <= interrupts;
        st_r   <= (st_r & ~clr_s) | set_s;
        irq_r  <= |st_r;
        if (commit_s && (widx_s == 32'(I_EN))) begin
          en_r <= en_wr_s[IW-1:0];
        end else begin
          en_r <= en_r;
        end
        if (commit_s && (widx_s == 32'(I_MODE))) begin
          mode_r <= mode_wr_s[IW-1:0];
        end else begin
          mode_r <= mode_r;
        end
      end
    end

    assign irq_en_s   = en_r;
    assign irq_stat_s = st_r;
    assign irq_mode_s = mode_r;
    assign irq        = irq_r;
  end else begin : g_no_irq
    logic unused_irq_s;
    assign unused_irq_s = ^interrupts;
    assign irq_en_s     = {IW{1'b0}};
    assign irq_stat_s   = {IW{1'b0}};
    assign irq_mode_s   = {IW{1'b0}};
    assign irq          = 1'b0;
  end

  for (genvar i = 0; i < CTRL; i++) begin : g_ctrl_out
    assign ctrl[i*DATA_W +: DATA_W] = ctrl_r[i];
  end

  assign ctrlWr      = ctrlwr_r;
  assign bus.awReady = awready_r;
  assign bus.wReady  = wready_r;
  assign bus.bValid  = bvalid_r;
  assign bus.bResp   = bresp_r;
  assign bus.arReady = arready_r;
  assign bus.rValid  = rvalid_r;
  assign bus.rData   = rdata_r;
  assign bus.rResp   = rresp_r;

endmodule
